// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcodes,
// funct fields, ALU operation selects and ALU control codes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

endpackage

// File: rtl/mips_multicycle_ctrl_aludec.sv
// ALU decoder: maps the FSM's aluop and the instruction funct field onto the
// 3-bit control code consumed by the voted ALU.
module aludec
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS datapath: state register,
// next-state logic, per-state output decode and the PC enable gate.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       illegal
);

    state_t     state, next_state;
    logic       pcwrite, branch, state_valid;
    logic       memwrite_s, irwrite_s, regwrite_s;
    logic [1:0] aluop;
    logic [2:0] dec_control;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= next_state;
    end

    always_comb begin
        next_state  = S_FETCH;
        pcwrite     = 1'b0;
        branch      = 1'b0;
        memwrite_s  = 1'b0;
        irwrite_s   = 1'b0;
        regwrite_s  = 1'b0;
        iord        = 1'b0;
        memtoreg    = 1'b0;
        regdst      = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        pcsrc       = 2'b00;
        aluop       = ALUOP_ADD;
        illegal     = 1'b0;
        state_valid = 1'b1;
        case (state)
            S_FETCH: begin
                irwrite_s  = 1'b1;
                pcwrite    = 1'b1;
                alusrcb    = 2'b01;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_RTYPEEX;
                    OP_BEQ:       next_state = S_BEQEX;
                    OP_ADDI:      next_state = S_ADDIEX;
                    OP_J:         next_state = S_JEX;
                    default: begin
                        next_state = S_FETCH;
                        illegal    = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                if (op == OP_LW)      next_state = S_MEMRD;
                else if (op == OP_SW) next_state = S_MEMWR;
                else                  next_state = S_FETCH;
            end
            S_MEMRD: begin
                iord       = 1'b1;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                regwrite_s = 1'b1;
                memtoreg   = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                memwrite_s = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_FUNCT;
                next_state = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                regwrite_s = 1'b1;
                regdst     = 1'b1;
            end
            S_BEQEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                next_state = S_ADDIWB;
            end
            S_ADDIWB: regwrite_s = 1'b1;
            S_JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: state_valid = 1'b0;
        endcase
    end

    aludec u_aludec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (dec_control)
    );

    // Enables are gated by reset so an aborting reset suppresses the write
    // even before the state register has been cleared.
    assign alucontrol = state_valid ? dec_control : 3'b000;
    assign pcen       = ~reset & (pcwrite | (branch & zero));
    assign memwrite   = ~reset & memwrite_s;
    assign irwrite    = ~reset & irwrite_s;
    assign regwrite   = ~reset & regwrite_s;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: an instruction-level model queues
// the expected control word for every cycle; a negedge monitor pops and compares.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'b100011;
    logic [5:0] funct = 6'b000000;
    logic       zero = 1'b0;
    logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca, illegal;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [15:0] actual;
    logic [15:0] exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cycle_no = 0;

    mips_multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
        .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign actual = {pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
                     alusrcb, pcsrc, alucontrol, illegal};

    function automatic int cpi(input logic [5:0] o);
        case (o)
            6'b100011:                       return 5;
            6'b101011, 6'b000000, 6'b001000: return 4;
            6'b000100, 6'b000010:            return 3;
            default:                         return 2;
        endcase
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic logic [15:0] pack(input logic pe, mw, iw, rw, io, mt, rd, sa,
                                         input logic [1:0] sb, ps, input logic [2:0] alu,
                                         input logic il);
        return {pe, mw, iw, rw, io, mt, rd, sa, sb, ps, alu, il};
    endfunction

    function automatic logic [15:0] reset_word();
        return pack(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0);
    endfunction

    // Expected control word for cycle 'step' (0 = fetch) of an instruction.
    function automatic logic [15:0] model(input logic [5:0] o, input logic [5:0] f,
                                          input logic z, input int step);
        logic pe = 0, mw = 0, iw = 0, rw = 0, io = 0, mt = 0, rd = 0, sa = 0, il = 0;
        logic [1:0] sb = 2'b00, ps = 2'b00;
        logic [2:0] alu = 3'b010;
        if (step == 0) begin
            iw = 1; pe = 1; sb = 2'b01;
        end else if (step == 1) begin
            sb = 2'b11; il = (cpi(o) == 2);
        end else begin
            case (o)
                6'b100011, 6'b101011: begin
                    if (step == 2) begin sa = 1; sb = 2'b10; end
                    else if (step == 3) begin io = 1; mw = (o == 6'b101011); end
                    else begin rw = 1; mt = 1; end
                end
                6'b000000: begin
                    if (step == 2) begin sa = 1; alu = funct_alu(f); end
                    else begin rw = 1; rd = 1; end
                end
                6'b000100: begin
                    sa = 1; alu = 3'b110; ps = 2'b01; pe = z;
                end
                6'b001000: begin
                    if (step == 2) begin sa = 1; sb = 2'b10; end
                    else rw = 1;
                end
                default: begin
                    ps = 2'b10; pe = 1;
                end
            endcase
        end
        return pack(pe, mw, iw, rw, io, mt, rd, sa, sb, ps, alu, il);
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Runs one instruction; abort_step >= 0 fires an async reset late in that cycle.
    task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f,
                                 input logic zbeq, input int abort_step);
        int n = cpi(o);
        for (int s = 0; s < n; s++) begin
            @(posedge clk);
            #1;
            reset = 1'b0;
            op    = o;
            funct = f;
            zero  = (o == 6'b000100 && s == 2) ? zbeq : 1'($urandom);
            exp_q.push_back(model(o, f, zero, s));
            if (s == abort_step) begin
                #6;
                reset = 1'b1;
                #1;
                checkOutput("async_reset", actual, reset_word());
                @(posedge clk);
                #1;
                exp_q.push_back(reset_word());
                return;
            end
        end
    endtask

    always @(negedge clk) begin
        cycle_no++;
        if (exp_q.size() > 0)
            checkOutput($sformatf("cycle%0d op=%b funct=%b", cycle_no, op, funct),
                        actual, exp_q.pop_front());
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [5:0] legal_ops[6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
        logic [5:0] fns[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [5:0] o, f;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            exp_q.push_back(reset_word());
        end
        applyStimulus(6'b100011, 6'b000000, 1'b0, -1);
        applyStimulus(6'b000000, 6'b100010, 1'b0, -1);
        applyStimulus(6'b000000, 6'b101010, 1'b0, -1);
        applyStimulus(6'b000100, 6'b000000, 1'b1, -1);
        applyStimulus(6'b000100, 6'b000000, 1'b0, -1);
        applyStimulus(6'b101011, 6'b000000, 1'b0, -1);
        applyStimulus(6'b000010, 6'b000000, 1'b0, -1);
        applyStimulus(6'b111111, 6'b000000, 1'b0, -1);
        applyStimulus(6'b001000, 6'b000000, 1'b0, -1);
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                o = 6'($urandom);
                if (cpi(o) != 2) o = 6'b110001;
            end else begin
                o = legal_ops[$urandom_range(0, 5)];
            end
            f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
            applyStimulus(o, f, 1'($urandom), -1);
        end
        applyStimulus(6'b000000, 6'b100100, 1'b0, 3);
        applyStimulus(6'b100011, 6'b000000, 1'b0, -1);
        applyStimulus(6'b000000, 6'b100101, 1'b0, -1);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Control unit for the multicycle MIPS processor. It sequences the shared datapath: one memory, the register file, the voted ALU and the PC/IR/data flops. It is a Moore state machine that decodes the instruction held in the IR. Each cycle it drives the mux selects, the write enables and the 3-bit ALU control code that the ALU consumes.

## Interface
Parameters: none. All encodings are fixed in the shared package.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag, voted
- pcen  out  1  PC flop enable: `pcwrite | (branch & zero)`
- memwrite  out  1  memory write enable
- irwrite  out  1  IR flop enable
- regwrite  out  1  register-file we3
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memtoreg  out  1  writeback data select: 0 = ALUOut, 1 = MDR
- regdst  out  1  write register select: 0 = rt, 1 = rd
- alusrca  out  1  ALU A select: 0 = PC, 1 = register A
- alusrcb  out  2  ALU B select: 00 = B, 01 = 4, 10 = signimm, 11 = signimm<<2
- pcsrc  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- alucontrol  out  3  ALU control code: 010 add, 110 sub, 000 and, 001 or, 111 slt
- illegal  out  1  high in DECODE when op is unsupported

## Operation
- State register, 4 bits. Resets asynchronously to FETCH.
- Outputs are decoded from the state only; `zero` enters only through pcen. Any signal not listed for a state is 0.
- FETCH: irwrite = 1, pcwrite = 1, alusrcb = 01, aluop = 00. Next state is DECODE.
- DECODE: alusrcb = 11, aluop = 00. Next state depends on op:
  - lw (100011) or sw (101011) → MEMADR
  - R-type (000000) → RTYPEEX
  - beq (000100) → BEQEX
  - addi (001000) → ADDIEX
  - j (000010) → JEX
  - any other op → FETCH, with illegal = 1 for that cycle
- MEMADR: alusrca = 1, alusrcb = 10. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: iord = 1. Next state is MEMWB.
- MEMWB: regwrite = 1, memtoreg = 1, regdst = 0. Next state is FETCH.
- MEMWR: iord = 1, memwrite = 1. Next state is FETCH.
- RTYPEEX: alusrca = 1, alusrcb = 00, aluop = 10. Next state is RTYPEWB.
- RTYPEWB: regwrite = 1, regdst = 1, memtoreg = 0. Next state is FETCH.
- BEQEX: alusrca = 1, alusrcb = 00, aluop = 01, pcsrc = 01, branch = 1. Next state is FETCH.
- ADDIEX: alusrca = 1, alusrcb = 10, aluop = 00. Next state is ADDIWB.
- ADDIWB: regwrite = 1, regdst = 0, memtoreg = 0. Next state is FETCH.
- JEX: pcsrc = 10, pcwrite = 1. Next state is FETCH.
- ALU decoder mapping from aluop to alucontrol:
  - aluop 00 → 010 (add)
  - aluop 01 → 110 (sub)
  - aluop 10, decoded by funct: 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111; any other funct → 010
  - aluop 11 → 010
- Unencoded state values → FETCH on the next edge, with all outputs 0 while in that state.

## Timing
- Cycles per instruction, counted FETCH to the next FETCH:
  - lw: 5
  - sw, R-type, addi: 4
  - beq, j: 3
  - illegal op: 2
- Write enables take effect at the rising edge that ends the state in which they are asserted.
- pcen in BEQEX is combinational on zero. zero must settle within that cycle; there is no registered path from zero.
- While reset is high:
  - state = FETCH
  - pcen, irwrite, memwrite, regwrite are forced to 0
  - other outputs show FETCH values: alusrcb = 01, alucontrol = 010, everything else 0
- On the first rising edge after reset deasserts, FETCH executes normally.
- Reset asserted mid-instruction aborts it immediately. No partial write occurs after the reset edge.
- op and funct are sampled only in DECODE, MEMADR (op only) and RTYPEEX. The IR is stable in all of these because irwrite is high only in FETCH.

## Structure
- Shared package `mips_ctrl_pkg` holds:
  - state enumeration, 4-bit
  - opcode constants: OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J
  - funct constants
  - ALU control constants ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  - aluop constants
- One sub-module, `aludec`: purely combinational, aluop + funct → alucontrol.
- Top level contains the state register, the next-state logic, the output decode and the pcen gate.

## Test plan
- Reset held for 3 cycles, then released with op = 100011 (lw):
  - during reset: pcen = irwrite = 0, alusrcb = 01
  - after release: states FETCH → DECODE → MEMADR → MEMRD → MEMWB → FETCH
  - regwrite = 1 and memtoreg = 1 only in cycle 5
- R-type, op = 0:
  - funct 100010 → alucontrol 110 in RTYPEEX, regwrite with regdst = 1 in the next cycle
  - repeat for funct 101010 → 111
- beq, op = 000100:
  - zero = 1 in BEQEX → pcen = 1 with pcsrc = 01
  - zero = 0 → pcen = 0
  - both cases return to FETCH after 3 cycles
- sw (op = 101011) → memwrite = 1 with iord = 1 in cycle 4, regwrite never asserted. j (op = 000010) → pcen = 1 with pcsrc = 10 in cycle 3.
- Illegal op = 111111 → illegal = 1 in DECODE, no write enable asserted, FETCH on the next cycle.
- Reset asserted asynchronously mid-cycle during RTYPEWB:
  - regwrite drops immediately
  - state = FETCH
  - no register write at the following edge
